// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch prediction and resolution for the five-stage RISC-V pipeline.
//
// IF side: a direct-mapped branch history table (2-bit saturating counter,
// tag and stored target per entry). It is looked up combinationally from
// if_pc and drives pred_taken / pred_target.
//
// ID side: combines the comparator result with the decoded branch and jump
// flags to find the actual direction. It detects mispredictions and spurious
// taken predictions on non-control-flow instructions, and it drives the PC
// redirect. The table and the performance counters are written on the
// rising edge that ends the resolve cycle.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   if_pc                 fetch PC used for lookup
//   pred_taken/target     prediction for if_pc
//   id_valid, id_stall    ID holds a real instruction / ID is stalled
//   id_pc                 PC of the ID instruction
//   id_br, id_jump        conditional branch / JAL-JALR
//   id_cmp                comparator result for the branch
//   id_target             computed branch/jump target
//   id_pred_taken/target  prediction carried down from IF
//   redirect, redirect_pc PC redirect and IF/ID flush request
//   br_cnt, miss_cnt      resolved control-flow count, redirect count
// -----------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic [31:0] id_pc,
  input  logic        id_br,
  input  logic        id_jump,
  input  logic        id_cmp,
  input  logic [31:0] id_target,
  input  logic        id_pred_taken,
  input  logic [31:0] id_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t table_q [ENTRIES];
  entry_t entry_d;
  logic   wr_en;

  logic [31:0] br_cnt_q,   br_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // PC bits [1:0] are always zero for aligned instructions and take no part
  // in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

  // ---------------------------------------------------------------------------
  // IF-side lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  entry_t           if_entry;
  logic             if_hit;

  assign if_idx   = if_pc[IDX_W+1:2];
  assign if_tag   = if_pc[31:IDX_W+2];
  assign if_entry = table_q[if_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

  assign pred_taken  = if_hit && if_entry.ctr[1];
  assign pred_target = if_hit ? if_entry.target : 32'h0;

  // ---------------------------------------------------------------------------
  // ID-side resolution
  // ---------------------------------------------------------------------------
  logic             res, is_cf, act_taken, mispredict, spurious;
  logic [31:0]      id_pc_plus4;
  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  entry_t           id_entry;
  logic             id_hit;

  assign res         = id_valid && !id_stall;
  assign is_cf       = id_br || id_jump;
  assign act_taken   = id_jump || (id_br && id_cmp);
  assign id_pc_plus4 = id_pc + 32'd4;

  // A taken prediction is also wrong when its target disagrees.
  assign mispredict = res && is_cf &&
                      ((act_taken != id_pred_taken) ||
                       (act_taken && id_pred_taken && (id_pred_target != id_target)));
  // A non-control-flow instruction that IF predicted taken fetched the wrong
  // path and must fall through.
  assign spurious   = res && !is_cf && id_pred_taken;

  // Redirect is held low while reset is asserted so the PC is not disturbed.
  assign redirect    = rst_n && (mispredict || spurious);
  assign redirect_pc = (mispredict && act_taken) ? id_target : id_pc_plus4;

  assign id_idx   = id_pc[IDX_W+1:2];
  assign id_tag   = id_pc[31:IDX_W+2];
  assign id_entry = table_q[id_idx];
  assign id_hit   = id_entry.valid && (id_entry.tag == id_tag);

  // Next value of the single entry that may be written this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    wr_en   = 1'b0;
    entry_d = id_entry;
    if (res && is_cf) begin
      if (id_hit) begin
        wr_en = 1'b1;
        if (id_jump) begin
          entry_d.ctr    = 2'b11;
          entry_d.target = id_target;
        end else if (act_taken) begin
          entry_d.ctr    = (id_entry.ctr == 2'b11) ? 2'b11 : id_entry.ctr + 2'd1;
          entry_d.target = id_target;
        end else begin
          entry_d.ctr    = (id_entry.ctr == 2'b00) ? 2'b00 : id_entry.ctr - 2'd1;
        end
      end else if (act_taken) begin
        // Only taken control flow allocates; not-taken misses stay out.
        wr_en          = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = id_tag;
        entry_d.target = id_target;
        entry_d.ctr    = id_jump ? 2'b11 : 2'b10;
      end
    end else if (spurious && id_hit) begin
      wr_en         = 1'b1;
      entry_d.valid = 1'b0;
    end
  end

  // Performance counters saturate instead of wrapping.
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (res && is_cf && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
    if (redirect && (miss_cnt_q != 32'hFFFF_FFFF))   miss_cnt_d = miss_cnt_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: the table is reset entry by entry; reset must give a known "weakly not-taken, invalid" state, which rules out a plain RAM macro here.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, ctr: 2'b01};
      end
      br_cnt_q   <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (wr_en) table_q[id_idx] <= entry_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_bht
//
// Directed checks of branch_resolve_bht. The bench covers lookup after
// reset, allocation, counter training and saturation, JAL target
// correction, stall and invalid suppression, spurious-prediction
// invalidation with PC wrap, same-cycle lookup/update and mid-stream reset.
// Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns later,
// well away from the next edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid, id_stall, id_br, id_jump, id_cmp, id_pred_taken;
  logic [31:0] id_pc, id_target, id_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc, br_cnt, miss_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;

  branch_resolve_bht #(.IDX_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .id_pc          (id_pc),
    .id_br          (id_br),
    .id_jump        (id_jump),
    .id_cmp         (id_cmp),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic br, input logic jp,
                       input logic c, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    id_valid       = v;
    id_stall       = st;
    id_br          = br;
    id_jump        = jp;
    id_cmp         = c;
    id_pc          = pc;
    id_target      = tgt;
    id_pred_taken  = pt;
    id_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset with a mispredicting JAL presented: redirect must stay low.
    rst_n = 1'b0;
    if_pc = 32'h100;
    drive(1, 0, 0, 1, 0, 32'h300, 32'h500, 0, 32'h0);
    #1 check("rst_redirect", redirect, 0);
    step();
    step();
    rst_n = 1'b1;
    idle();
    #1;
    check("rst_pred_taken", pred_taken, 0);
    check("rst_pred_target", pred_target, 32'h0);
    check("rst_br_cnt", br_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);

    // Taken branch at 0x100, predicted not-taken: allocate with ctr=10.
    drive(1, 0, 1, 0, 1, 32'h100, 32'h200, 0, 32'h0);
    #1;
    check("alloc_redirect", redirect, 1);
    check("alloc_redirect_pc", redirect_pc, 32'h200);
    step(); idle(); #1;
    check("alloc_pred_taken", pred_taken, 1);
    check("alloc_pred_target", pred_target, 32'h200);
    check("alloc_br_cnt", br_cnt, 1);
    check("alloc_miss_cnt", miss_cnt, 1);

    // Not taken while predicted taken: ctr 10 -> 01, redirect to fall-through.
    drive(1, 0, 1, 0, 0, 32'h100, 32'h200, 1, 32'h200);
    #1;
    check("nt1_redirect", redirect, 1);
    check("nt1_redirect_pc", redirect_pc, 32'h104);
    step(); idle(); #1;
    check("nt1_pred_taken", pred_taken, 0);
    check("nt1_pred_target", pred_target, 32'h200);

    // Not taken again, correctly predicted: ctr 01 -> 00.
    drive(1, 0, 1, 0, 0, 32'h100, 32'h200, 0, 32'h200);
    #1;
    check("nt2_redirect", redirect, 0);
    check("nt2_redirect_pc", redirect_pc, 32'h104);
    step(); idle(); #1;
    check("nt2_pred_taken", pred_taken, 0);
    check("nt2_br_cnt", br_cnt, 3);
    check("nt2_miss_cnt", miss_cnt, 2);

    // Three taken resolutions: ctr 00 -> 01 -> 10 -> 11.
    drive(1, 0, 1, 0, 1, 32'h100, 32'h200, 0, 32'h200);
    #1 check("t1_redirect_pc", redirect_pc, 32'h200);
    step();
    drive(1, 0, 1, 0, 1, 32'h100, 32'h200, 0, 32'h200);
    #1 check("t2_redirect", redirect, 1);
    step();
    drive(1, 0, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200);
    #1 check("t3_redirect", redirect, 0);
    step(); idle(); #1;
    check("t3_pred_taken", pred_taken, 1);
    check("t3_br_cnt", br_cnt, 6);
    check("t3_miss_cnt", miss_cnt, 4);

    // A fourth taken must saturate at 11, so one not-taken leaves 10.
    drive(1, 0, 1, 0, 1, 32'h100, 32'h200, 1, 32'h200);
    step();
    drive(1, 0, 1, 0, 0, 32'h100, 32'h200, 1, 32'h200);
    #1 check("sat_nt_redirect_pc", redirect_pc, 32'h104);
    step(); idle(); #1;
    check("sat_pred_taken", pred_taken, 1);
    check("sat_br_cnt", br_cnt, 8);
    check("sat_miss_cnt", miss_cnt, 5);

    // JAL at 0x300 (same index as 0x100) with the wrong carried target.
    drive(1, 0, 0, 1, 0, 32'h300, 32'h500, 1, 32'h400);
    #1;
    check("jal_redirect", redirect, 1);
    check("jal_redirect_pc", redirect_pc, 32'h500);
    step(); idle();
    if_pc = 32'h300;
    #1;
    check("jal_pred_taken", pred_taken, 1);
    check("jal_pred_target", pred_target, 32'h500);
    if_pc = 32'h100;
    #1;
    check("evicted_pred_taken", pred_taken, 0);
    check("evicted_pred_target", pred_target, 32'h0);

    // Stalled and invalid resolutions are ignored.
    drive(1, 1, 1, 0, 1, 32'h140, 32'h999, 0, 32'h0);
    #1 check("stall_redirect", redirect, 0);
    step();
    drive(0, 0, 0, 1, 0, 32'h140, 32'h999, 0, 32'h0);
    #1 check("invalid_redirect", redirect, 0);
    step(); idle();
    if_pc = 32'h140;
    #1;
    check("stall_pred_taken", pred_taken, 0);
    check("stall_br_cnt", br_cnt, 9);
    check("stall_miss_cnt", miss_cnt, 6);

    // Allocate index 63 from 0xFC.
    drive(1, 0, 1, 0, 1, 32'hFC, 32'h80, 0, 32'h0);
    #1 check("fc_redirect_pc", redirect_pc, 32'h80);
    step(); idle();
    if_pc = 32'hFC;
    #1;
    check("fc_pred_taken", pred_taken, 1);
    check("fc_pred_target", pred_target, 32'h80);

    // Spurious prediction at 0xFFFF_FFFC: fall-through wraps, tag differs.
    drive(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h1234);
    #1;
    check("wrap_redirect", redirect, 1);
    check("wrap_redirect_pc", redirect_pc, 32'h0);
    step(); idle(); #1;
    check("wrap_keeps_entry", pred_taken, 1);

    // Spurious prediction at 0xFC: tag matches, entry invalidated.
    drive(1, 0, 0, 0, 0, 32'hFC, 32'h0, 1, 32'h80);
    #1 check("spur_redirect_pc", redirect_pc, 32'h100);
    step(); idle(); #1;
    check("spur_pred_taken", pred_taken, 0);
    check("spur_pred_target", pred_target, 32'h0);
    check("spur_br_cnt", br_cnt, 10);
    check("spur_miss_cnt", miss_cnt, 9);

    // Same-cycle lookup and update at 0x300: ctr 11 -> 10 -> 01.
    if_pc = 32'h300;
    drive(1, 0, 1, 0, 0, 32'h300, 32'h500, 1, 32'h500);
    #1 check("same1_redirect_pc", redirect_pc, 32'h304);
    step();
    drive(1, 0, 1, 0, 0, 32'h300, 32'h500, 1, 32'h500);
    #1;
    check("same2_old_pred", pred_taken, 1);
    check("same2_redirect", redirect, 1);
    step(); idle(); #1;
    check("same_new_pred", pred_taken, 0);
    check("same_new_target", pred_target, 32'h500);
    check("same_br_cnt", br_cnt, 12);
    check("same_miss_cnt", miss_cnt, 11);

    // Reset mid-stream with a taken branch pending: update discarded.
    drive(1, 0, 1, 0, 1, 32'h140, 32'h240, 0, 32'h0);
    rst_n = 1'b0;
    #1 check("midrst_redirect", redirect, 0);
    step();
    rst_n = 1'b1;
    idle();
    #1;
    check("midrst_pred_300", pred_taken, 0);
    check("midrst_target_300", pred_target, 32'h0);
    if_pc = 32'h140;
    #1;
    check("midrst_pred_140", pred_taken, 0);
    check("midrst_br_cnt", br_cnt, 0);
    check("midrst_miss_cnt", miss_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
